// File: rtl/gate3_selftest_ctrl.sv
// Self-test sequencer for a 3-input gate: walks {a,b,c} through 0..7, samples the gate
// output at the end of each hold window and reports mismatches. Optional: GATE3_SELFTEST_STOP_ON_FAIL_EN.
module gate3_selftest_ctrl #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected_tt,
    input  logic       dut_f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t          state_reg;
    logic [2:0]      idx_reg;
    logic [CW-1:0]   cnt_reg;
    logic [7:0]      tt_reg;
    logic            mismatch;
    logic            end_run;

    // dut_f is combinational from the registered a/b/c, so it matches idx_reg this cycle
    assign mismatch = (dut_f != tt_reg[idx_reg]);

`ifdef GATE3_SELFTEST_STOP_ON_FAIL_EN
    assign end_run = mismatch || (idx_reg == 3'd7);
`else
    assign end_run = (idx_reg == 3'd7);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            cnt_reg   <= '0;
            tt_reg    <= 8'h00;
            {a, b, c} <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    {a, b, c} <= 3'b000;
                    busy      <= 1'b0;
                    if (start) begin
                        tt_reg    <= expected_tt;
                        err_count <= 4'd0;
                        fail_vec  <= 8'h00;
                        pass      <= 1'b0;
                        idx_reg   <= 3'd0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= APPLY;
                    end
                end
                APPLY: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (mismatch) begin
                            fail_vec[idx_reg] <= 1'b1;
                            err_count         <= err_count + 4'd1;
                        end
                        if (end_run) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            {a, b, c} <= 3'b000;
                        end else begin
                            idx_reg   <= idx_reg + 3'd1;
                            {a, b, c} <= idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    // err_count is final here; done and pass become visible together
                    done      <= 1'b1;
                    pass      <= (err_count == 4'd0);
                    {a, b, c} <= 3'b000;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate3_selftest_ctrl.sv
// Scoreboard bench for gate3_selftest_ctrl: an H=4 instance against NOR/stuck gates
// and an H=1 instance against a NAND gate.
module tb_gate3_selftest_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start4 = 1'b0, start1 = 1'b0;
    logic [7:0] tt4 = 8'h00, tt1 = 8'h00;
    logic       f4, f1;
    logic       a4, b4, c4, busy4, done4, pass4;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [3:0] err4, err1;
    logic [7:0] fv4, fv1;
    int         mode4 = 0;   // 0 = NOR, 1 = stuck-at-0, 2 = stuck-at-1

    assign f4 = (mode4 == 0) ? ~(a4 | b4 | c4) : (mode4 == 2);
    assign f1 = ~(a1 & b1 & c1);

    gate3_selftest_ctrl #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .expected_tt(tt4), .dut_f(f4),
        .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .fail_vec(fv4)
    );

    gate3_selftest_ctrl #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected_tt(tt1), .dut_f(f1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n++;

    typedef struct {
        int         at;
        logic       p;
        logic [3:0] err;
        logic [7:0] fv;
    } exp_t;
    exp_t q4[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    // Monitors: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        exp_t e;
        if (done4 === 1'b1) begin
            $display("done4 edge=%0d pass=%0b err=%0d fail_vec=%02h", edge_n, pass4, err4, fv4);
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done4_unexpected: got done at edge %0d want none", edge_n);
            end else begin
                e = q4.pop_front();
                check("done4_edge", 32'(edge_n), 32'(e.at));
                check("pass4", 32'(pass4), 32'(e.p));
                check("err4", 32'(err4), 32'(e.err));
                check("fail_vec4", 32'(fv4), 32'(e.fv));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1 === 1'b1) begin
            $display("done1 edge=%0d pass=%0b err=%0d fail_vec=%02h", edge_n, pass1, err1, fv1);
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done1_unexpected: got done at edge %0d want none", edge_n);
            end else begin
                e = q1.pop_front();
                check("done1_edge", 32'(edge_n), 32'(e.at));
                check("pass1", 32'(pass1), 32'(e.p));
                check("err1", 32'(err1), 32'(e.err));
                check("fail_vec1", 32'(fv1), 32'(e.fv));
            end
        end
    end

    // Issues start on the H=4 instance; returns at the negedge after accepting edge k
    task automatic start_run4(input logic [7:0] tt, input int mode, input bit expect_done,
                              input int lat, input logic p, input logic [3:0] err,
                              input logic [7:0] fv);
        int k;
        @(negedge clk);
        tt4    = tt;
        mode4  = mode;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        k = edge_n;
        if (expect_done) q4.push_back('{k + lat, p, err, fv});
        $display("start4 edge=%0d tt=%02h mode=%0d", k, tt, mode);
        @(negedge clk);
        start4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("reset4", 32'({a4, b4, c4, busy4, done4, pass4, err4, fv4}), 32'd0);
        check("reset1", 32'({a1, b1, c1, busy1, done1, pass1, err1, fv1}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good NOR gate: vectors step every 4 cycles, done after edge k+33
        start_run4(8'h01, 0, 1'b1, 33, 1'b1, 4'd0, 8'h00);
        for (int j = 0; j < 32; j++) begin
            if (j > 0) @(negedge clk);
            check("vec4", 32'({a4, b4, c4}), j / 4);
            check("busy4", 32'(busy4), 32'd1);
        end
        @(negedge clk);
        check("done_state_abc4", 32'({a4, b4, c4}), 32'd0);
        check("done_state_busy4", 32'(busy4), 32'd0);
        repeat (4) @(negedge clk);

        // Stuck-at-0: only vector 0 (expected 1) mismatches
        start_run4(8'h01, 1, 1'b1,
`ifdef GATE3_SELFTEST_STOP_ON_FAIL_EN
                   5,
`else
                   33,
`endif
                   1'b0, 4'd1, 8'h01);
        repeat (36) @(negedge clk);

        // Stuck-at-1: vectors 1..7 mismatch
`ifdef GATE3_SELFTEST_STOP_ON_FAIL_EN
        start_run4(8'h01, 2, 1'b1, 9, 1'b0, 4'd1, 8'h02);
`else
        start_run4(8'h01, 2, 1'b1, 33, 1'b0, 4'd7, 8'hFE);
`endif
        repeat (36) @(negedge clk);

        // start pulse and expected_tt change during vector 2 must not disturb the run
        start_run4(8'h01, 0, 1'b1, 33, 1'b1, 4'd0, 8'h00);
        repeat (9) @(negedge clk);
        start4 = 1'b1;
        tt4    = 8'hFF;
        @(negedge clk);
        start4 = 1'b0;
        check("midrun_vec4", 32'({a4, b4, c4}), 32'd2);
        check("midrun_busy4", 32'(busy4), 32'd1);
        repeat (30) @(negedge clk);

        // Reset during vector 3 abandons the run without a done pulse
        start_run4(8'h01, 0, 1'b0, 0, 1'b0, 4'd0, 8'h00);
        repeat (13) @(negedge clk);
        check("prereset_vec4", 32'({a4, b4, c4}), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset4", 32'({a4, b4, c4, busy4, done4, pass4, err4, fv4}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        start_run4(8'h01, 0, 1'b1, 33, 1'b1, 4'd0, 8'h00);
        repeat (36) @(negedge clk);

        // H=1 NAND: a new vector every cycle, done after edge k+9
        tt1    = 8'h7F;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        k = edge_n;
        q1.push_back('{k + 9, 1'b1, 4'd0, 8'h00});
        $display("start1 edge=%0d tt=%02h", k, tt1);
        @(negedge clk);
        start1 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) @(negedge clk);
            check("vec1", 32'({a1, b1, c1}), j);
        end
        repeat (6) @(negedge clk);

        check("q4_drained", q4.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate3_selftest_ctrl.md
# gate3_selftest_ctrl

Self-test sequencer for a 3-input combinational gate (NOR, NAND, AND, OR, XOR …). It drives the gate's `a`/`b`/`c` inputs through all eight combinations in ascending order and holds each one for a programmable number of cycles. It samples the gate output at the end of each hold window, compares it against a caller-supplied truth table, and reports the per-vector mismatches, an error count and pass/fail. It sits between a gate instance and the lab's bring-up/status logic, replacing the hand-sequenced stimulus loop.

## Interface
- `HOLD_CYCLES`, default 4: cycles each input vector is held; legal range ≥1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a run; sampled only in IDLE.
- `expected_tt` input 8: bit i = expected gate output when {a,b,c} = i (a is MSB); NOR = 8'h01.
- `dut_f` input 1: gate output under test.
- `a`, `b`, `c` output 1 each: registered gate inputs.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse at end of run.
- `pass` output 1: last completed run had zero mismatches.
- `err_count` output 4: mismatches in last run, 0–8.
- `fail_vec` output 8: bit i set if vector i mismatched.

## Operation
- States are IDLE, APPLY and DONE.
- **IDLE:** `a`,`b`,`c` = 0 and `busy` = 0. When `start`=1 on an edge:
  - latch `expected_tt` into an internal register; later changes to the port are ignored until the next run;
  - clear `err_count`, `fail_vec` and `pass`;
  - set vector index = 0 and hold counter = 0;
  - set `busy` = 1 and go to APPLY.
- **APPLY:**
  - `{a,b,c}` = vector index.
  - The hold counter increments each cycle.
  - On the cycle where the counter = HOLD_CYCLES−1:
    - compare `dut_f` with the latched `tt[index]`;
    - on mismatch, set `fail_vec[index]` and increment `err_count`;
    - reset the counter.
  - If index = 7, go to DONE; otherwise increment the index.
- **DONE (one cycle):**
  - `done` = 1 and `busy` = 0;
  - `pass` = (`err_count` == 0);
  - `{a,b,c}` = 0;
  - return to IDLE.
- `err_count`, `fail_vec` and `pass` hold their values until the next accepted `start` or `rst`.
- `start` while `busy` or in DONE is ignored. It is not queued.
- `start` held high continuously starts a new run on the first IDLE cycle after DONE.
- Hold counter width is $clog2(HOLD_CYCLES) bits, minimum 1. Vector index is 3 bits. The index does not wrap; the run terminates at 7.

## Timing
- Reset (edge with `rst`=1): state IDLE; `a`=`b`=`c`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0. An in-flight run is abandoned with no `done` pulse. `rst` has priority over `start`.
- `start` accepted at edge k:
  - vector i is driven during cycles k+1+i·H … k+(i+1)·H, where H = HOLD_CYCLES;
  - `dut_f` for vector i is sampled at edge k+(i+1)·H;
  - `done` and final results are visible after edge k+8H+1, for exactly one cycle.
- `busy` is high after edge k through the last APPLY cycle, and low in DONE.
- `dut_f` is treated as combinational from `a`,`b`,`c`. For H=1 the gate gets the same cycle to settle.

## Configuration
- Macro: `GATE3_SELFTEST_STOP_ON_FAIL_EN`.
- **Defined:** the first mismatch ends the run.
  - The state goes to DONE after that sample edge.
  - `err_count` = 1 and exactly one `fail_vec` bit is set.
  - `done` appears after edge k+(i+1)·H+1, where i is the failing vector.
- **Undefined:** all eight vectors are always applied, and `err_count` can reach 8.

## Test plan
- Behavioral NOR model, `expected_tt`=8'h01, H=4, `start` at edge k:
  - {a,b,c} steps 000→111 every 4 cycles;
  - `done` pulse after edge k+33 → `pass`=1, `err_count`=0, `fail_vec`=8'h00.
- Stuck-at-0 gate, `expected_tt`=8'h01 → `pass`=0, `err_count`=1, `fail_vec`=8'h01.
- Stuck-at-1 gate, `expected_tt`=8'h01:
  - without macro → `err_count`=7, `fail_vec`=8'hFE;
  - with macro → `done` after edge k+9, `err_count`=1, `fail_vec`=8'h02.
- Pulse `start` again during vector 2, and change `expected_tt` mid-run → no restart, results unaffected, single `done`.
- `rst` asserted while vector 3 is applied:
  - next edge all outputs are 0 and no `done` pulse occurs;
  - a new `start` gives a full, correct run.
- H=1, NAND model, `expected_tt`=8'h7F → vectors change every cycle, `done` after edge k+9, `pass`=1.
